matmul_nxn_stream: RTL

//  Parametrised N x N integer matrix multiplier, C = A x B, on AXI-Stream in/out.

---
 rtl/matmul_pkg.sv | 35 +++
 rtl/matmul_mac_unit.sv | 25 ++
 rtl/matmul_nxn_stream.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
//   Definitions shared by the N x N stream matrix multiplier:
//   - state_t   : controller state encoding
//   - DIM_MIN/DIM_MAX and dim_legal() : legal matrix dimension range
//   - idx_width()/rc_width() : counter widths for element and row/col indices
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MAC    = 3'd3,
        SEND   = 3'd4
    } state_t;

    localparam int DIM_MIN = 2;
    localparam int DIM_MAX = 8;

    // Width of a flat element index 0 .. dim*dim-1.
    function automatic int idx_width(input int dim);
        return $clog2(dim * dim);
    endfunction

    // Width of a row or column index 0 .. dim-1.
    function automatic int rc_width(input int dim);
        return $clog2(dim);
    endfunction

    function automatic bit dim_legal(input int dim);
        return (dim >= DIM_MIN) && (dim <= DIM_MAX);
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// -----------------------------------------------------------------------------
// matmul_mac_unit
//   Single multiply-accumulate: acc_out = acc_in + mul_a * mul_b, all modulo
//   2^pDATA_WIDTH (sign-agnostic, no saturation). Purely combinational so the
//   parent can issue and write back one operation per clock.
// Ports
//   mul_a   in  pDATA_WIDTH  A operand
//   mul_b   in  pDATA_WIDTH  B operand
//   acc_in  in  pDATA_WIDTH  current partial sum
//   acc_out out pDATA_WIDTH  updated partial sum
// -----------------------------------------------------------------------------
module matmul_mac_unit #(
    parameter int pDATA_WIDTH = 32
) (
    input  logic [pDATA_WIDTH-1:0] mul_a,
    input  logic [pDATA_WIDTH-1:0] mul_b,
    input  logic [pDATA_WIDTH-1:0] acc_in,
    output logic [pDATA_WIDTH-1:0] acc_out
);

    // Product is evaluated in the pDATA_WIDTH context of the assignment, so
    // the upper half of the full product is discarded by construction.
    assign acc_out = acc_in + mul_a * mul_b;

endmodule

// File: rtl/matmul_nxn_stream.sv
// -----------------------------------------------------------------------------
// matmul_nxn_stream
//   N x N integer matrix multiplier C = A x B on AXI-Stream.
//   A then B arrive row-major on ss_*; C leaves row-major on sm_*.
//   Each B[r][c] beat triggers N MAC cycles: C[i][c] += A[i][r] * B[r][c].
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ap_start            start pulse, honoured only in IDLE
//   ap_idle             high while IDLE
//   ap_done             one-cycle pulse after the last C beat is accepted
//   err_tlast           sticky: ss_tlast seen on a non-final beat or missing on
//                       the final B beat; cleared by ap_start
//   ss_tvalid/tdata/tlast/tready   input stream (A then B)
//   sm_tvalid/tdata/tlast/tready   output stream (C)
// -----------------------------------------------------------------------------
module matmul_nxn_stream
    import matmul_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pDIM        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   err_tlast,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    if (!dim_legal(pDIM)) begin : g_dim_check
        $error("matmul_nxn_stream: pDIM must lie in 2..8");
    end

    localparam int IDX_W = idx_width(pDIM);
    localparam int RC_W  = rc_width(pDIM);
    localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(pDIM * pDIM - 1);
    localparam logic [RC_W-1:0]  LAST_RC   = RC_W'(pDIM - 1);

    state_t state, state_nxt;

    logic [pDATA_WIDTH-1:0] a_mem [pDIM][pDIM];
    logic [pDATA_WIDTH-1:0] c_mem [pDIM][pDIM];

    // Latched B element and its coordinates for the current MAC burst.
    logic [pDATA_WIDTH-1:0] b_val;
    logic [RC_W-1:0]        b_row;
    logic [RC_W-1:0]        b_col;
    logic                   b_final;

    // One element counter serves all three streaming phases; row/col shadow
    // it so no divider is needed to split k into k/N and k%N.
    logic [IDX_W-1:0] elem_cnt, elem_nxt;
    logic [RC_W-1:0]  row_cnt, row_nxt;
    logic [RC_W-1:0]  col_cnt, col_nxt;
    logic [RC_W-1:0]  mac_cnt;

    logic elem_last;
    logic mac_last;
    logic in_load;
    logic in_send;
    logic ss_hs;
    logic sm_hs;

    logic [pDATA_WIDTH-1:0] mac_sum;

    // Handshakes are derived from state directly rather than from the ready
    // outputs so the FSM comb block never reads a signal it also drives.
    assign in_load   = (state == LOAD_A) || (state == LOAD_B);
    assign in_send   = (state == SEND);
    assign ss_hs     = ss_tvalid && in_load;
    assign sm_hs     = sm_tready && in_send;
    assign elem_last = (elem_cnt == LAST_ELEM);
    assign mac_last  = (mac_cnt == LAST_RC);

    // -------------------------------------------------------------------------
    // Element / row / column advance, wrapping to zero after the last element
    // so the next phase starts at index 0 without an extra clear.
    // -------------------------------------------------------------------------
    always_comb begin
        elem_nxt = elem_cnt + 1'b1;
        row_nxt  = row_cnt;
        col_nxt  = col_cnt + 1'b1;
        if (col_cnt == LAST_RC) begin
            col_nxt = '0;
            row_nxt = row_cnt + 1'b1;
        end
        if (elem_last) begin
            elem_nxt = '0;
            row_nxt  = '0;
            col_nxt  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and stream/status outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        sm_tdata  = '0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                ss_tready = 1'b1;
                if (ss_hs && elem_last) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                ss_tready = 1'b1;
                if (ss_hs) state_nxt = MAC;
            end
            MAC: begin
                if (mac_last) state_nxt = b_final ? SEND : LOAD_B;
            end
            SEND: begin
                // Counters only move on sm_hs, so data and last hold during stalls.
                sm_tvalid = 1'b1;
                sm_tdata  = c_mem[row_cnt][col_cnt];
                sm_tlast  = elem_last;
                if (sm_hs && elem_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // MAC datapath: row i = mac_cnt of column b_col, using A[i][b_row].
    // -------------------------------------------------------------------------
    matmul_mac_unit #(
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_mac (
        .mul_a   (a_mem[mac_cnt][b_row]),
        .mul_b   (b_val),
        .acc_in  (c_mem[mac_cnt][b_col]),
        .acc_out (mac_sum)
    );

    // -------------------------------------------------------------------------
    // Storage, counters and status flags
    // -------------------------------------------------------------------------
    // NOTE: the A and C arrays are reset explicitly because C is visible on
    // sm_tdata and a reset mid-run must leave no stale partial sums behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < pDIM; r++) begin
                for (int c = 0; c < pDIM; c++) begin
                    a_mem[r][c] <= '0;
                    c_mem[r][c] <= '0;
                end
            end
            b_val     <= '0;
            b_row     <= '0;
            b_col     <= '0;
            b_final   <= 1'b0;
            elem_cnt  <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            mac_cnt   <= '0;
            ap_done   <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        for (int r = 0; r < pDIM; r++) begin
                            for (int c = 0; c < pDIM; c++) begin
                                c_mem[r][c] <= '0;
                            end
                        end
                        elem_cnt  <= '0;
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        mac_cnt   <= '0;
                        err_tlast <= 1'b0;
                    end
                end
                LOAD_A: begin
                    if (ss_hs) begin
                        a_mem[row_cnt][col_cnt] <= ss_tdata;
                        if (ss_tlast) err_tlast <= 1'b1;
                        elem_cnt <= elem_nxt;
                        row_cnt  <= row_nxt;
                        col_cnt  <= col_nxt;
                    end
                end
                LOAD_B: begin
                    if (ss_hs) begin
                        b_val   <= ss_tdata;
                        b_row   <= row_cnt;
                        b_col   <= col_cnt;
                        b_final <= elem_last;
                        mac_cnt <= '0;
                        // tlast must appear exactly on the final B element.
                        if (ss_tlast != elem_last) err_tlast <= 1'b1;
                        elem_cnt <= elem_nxt;
                        row_cnt  <= row_nxt;
                        col_cnt  <= col_nxt;
                    end
                end
                MAC: begin
                    c_mem[mac_cnt][b_col] <= mac_sum;
                    mac_cnt <= mac_cnt + 1'b1;
                end
                SEND: begin
                    if (sm_hs) begin
                        elem_cnt <= elem_nxt;
                        row_cnt  <= row_nxt;
                        col_cnt  <= col_nxt;
                        if (elem_last) ap_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
